// File: rtl/issue_pkg.sv
// Shared definitions for the dual-issue scoreboard: FSM states, field widths
// and the helper that maps an execute latency to a timer load value.
package issue_pkg;

   localparam int          REG_IDX_W = 5;
   localparam int          LAT_W     = 3;
   localparam int          NUM_REGS  = 32;
   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   // PAIR: both slots candidates; SLOT1: slot 0 already issued, slot 1 waiting;
   // FLUSH: one bubble cycle after a mispredict while the NOP pair sits in decode.
   typedef enum logic [1:0] {
      ST_PAIR  = 2'd0,
      ST_SLOT1 = 2'd1,
      ST_FLUSH = 2'd2
   } sb_state_e;

   // A zero latency still has to cover the issue cycle, so it loads 1.
   function automatic logic [LAT_W-1:0] load_value(input logic [LAT_W-1:0] lat);
      return (lat == '0) ? LAT_W'(1) : lat;
   endfunction

endpackage

// File: rtl/sb_reg_timer.sv
// Per-register pending-write countdown. Busy while the count is nonzero.
module sb_reg_timer
   import issue_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [LAT_W-1:0] lat,
   output logic             busy
);

   logic [LAT_W-1:0] count_reg;
   logic [LAT_W-1:0] count_next;

   // A new load wins over the decrement; an idle timer stays at zero.
   always_comb begin
      count_next = count_reg;
      if (load) begin
         count_next = load_value(lat);
      end else if (count_reg != '0) begin
         count_next = count_reg - LAT_W'(1);
      end
   end

   // Count register with synchronous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign busy = (count_reg != '0);

endmodule

// File: rtl/issue_scoreboard.sv
// Dual-issue scoreboard: per-register latency timers plus a PAIR/SLOT1/FLUSH
// issue FSM with Mealy outputs.
// Optional feature: define SB_PERF_CNT_EN to add saturating stall_cycles and
// split_count performance counters.
module issue_scoreboard
   import issue_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 d_valid,
   input  logic [REG_IDX_W-1:0] rs1_0,
   input  logic [REG_IDX_W-1:0] rs2_0,
   input  logic [REG_IDX_W-1:0] rd_0,
   input  logic                 we_0,
   input  logic [LAT_W-1:0]     lat_0,
   input  logic [REG_IDX_W-1:0] rs1_1,
   input  logic [REG_IDX_W-1:0] rs2_1,
   input  logic [REG_IDX_W-1:0] rd_1,
   input  logic                 we_1,
   input  logic [LAT_W-1:0]     lat_1,
   input  logic                 br_mispredict,
   output logic                 stall_F,
   output logic                 stall_D,
   output logic                 flush_D,
   output logic                 issue0,
   output logic                 issue1,
   output logic [31:0]          busy_vec
`ifdef SB_PERF_CNT_EN
   ,
   output logic [31:0]          stall_cycles,
   output logic [31:0]          split_count
`endif
);

   sb_state_e             state_reg;
   sb_state_e             state_next;
   logic [NUM_REGS-1:0]   busy_raw;
   logic                  stall_int;
   logic                  haz0;
   logic                  haz1;
   logic                  intra1;

   // x0 is hardwired and never has a pending write.
   assign busy_raw[0] = 1'b0;

   genvar gi;
   generate
      for (gi = 1; gi < NUM_REGS; gi++) begin : g_timer
         logic hit0;
         logic hit1;
         // Slot 1 is the younger instruction, so its latency wins on a tie.
         assign hit0 = issue0 && we_0 && (rd_0 == REG_IDX_W'(gi));
         assign hit1 = issue1 && we_1 && (rd_1 == REG_IDX_W'(gi));

         sb_reg_timer u_timer (
            .clk   (clk),
            .reset (reset),
            .load  (hit0 || hit1),
            .lat   (hit1 ? lat_1 : lat_0),
            .busy  (busy_raw[gi])
         );
      end
   endgenerate

   // Hazard terms: busy sources/destination for each slot, plus slot 1's
   // dependence on slot 0's destination inside the same pair.
   always_comb begin
      haz0   = busy_raw[rs1_0] || busy_raw[rs2_0] || (we_0 && busy_raw[rd_0]);
      haz1   = busy_raw[rs1_1] || busy_raw[rs2_1] || (we_1 && busy_raw[rd_1]);
      intra1 = we_0 && (rd_0 != '0) &&
               ((rs1_1 == rd_0) || (rs2_1 == rd_0) || (we_1 && (rd_1 == rd_0)));
   end

   // Next state and Mealy outputs; reset and mispredict take priority.
   always_comb begin
      state_next = state_reg;
      issue0     = 1'b0;
      issue1     = 1'b0;
      stall_int  = 1'b0;
      flush_D    = 1'b0;
      if (reset) begin
         state_next = ST_PAIR;
      end else if (br_mispredict) begin
         flush_D    = 1'b1;
         state_next = ST_FLUSH;
      end else begin
         case (state_reg)
            ST_PAIR: begin
               if (d_valid) begin
                  if (haz0) begin
                     stall_int = 1'b1;
                  end else if (haz1 || intra1) begin
                     issue0     = 1'b1;
                     stall_int  = 1'b1;
                     state_next = ST_SLOT1;
                  end else begin
                     issue0 = 1'b1;
                     issue1 = 1'b1;
                  end
               end
            end
            ST_SLOT1: begin
               if (haz1) begin
                  stall_int = 1'b1;
               end else begin
                  issue1     = 1'b1;
                  state_next = ST_PAIR;
               end
            end
            ST_FLUSH: begin
               state_next = ST_PAIR;
            end
            default: begin
               state_next = ST_PAIR;
            end
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_PAIR;
      end else begin
         state_reg <= state_next;
      end
   end

   assign stall_F  = stall_int;
   assign stall_D  = stall_int;
   assign busy_vec = reset ? 32'd0 : busy_raw;

`ifdef SB_PERF_CNT_EN
   logic [31:0] stall_cycles_reg;
   logic [31:0] split_count_reg;

   // Saturating counters of stalled cycles and pair splits.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles_reg <= '0;
         split_count_reg  <= '0;
      end else begin
         if (stall_int && (stall_cycles_reg != '1)) begin
            stall_cycles_reg <= stall_cycles_reg + 32'd1;
         end
         if ((state_reg == ST_PAIR) && (state_next == ST_SLOT1) &&
             (split_count_reg != '1)) begin
            split_count_reg <= split_count_reg + 32'd1;
         end
      end
   end

   assign stall_cycles = stall_cycles_reg;
   assign split_count  = split_count_reg;
`endif

endmodule
